// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous first-word-fall-through code FIFO. Pushing while full drops the
// entry and raises a one-cycle overflow pulse, unless a pop frees a slot on the
// same edge.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = ovf_q;

  // Pointer advance; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    ovf_d    = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointers and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises SCLK/SDATA, samples data on SCLK falling
// edges, checks start/parity/stop and reports codes with error pulses.
// Mid-frame stalls longer than TIMEOUT_CYC abort the frame.
// Optional code FIFO enabled by defining PS2_RX_FIFO_EN.
module ps2_frame_rx
  import ps2_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_ODD  = 1,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              SDATA,
  input  logic              RD_EN,
  output logic              NEW_CODE,
  output logic [DATA_W-1:0] CODE,
  output logic              PARITY_ERR,
  output logic              FRAME_ERR,
  output logic              OVERFLOW
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdata_s1_q, sdata_s2_q;
  logic fall;

  ps2_state_e        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              accept_c, perr_c, ferr_c;
  logic              perr_q, ferr_q;

  // Two-flop synchronisers (idle bus = 1) plus a third SCLK stage for edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_s1_q  <= 1'b1;
      sclk_s2_q  <= 1'b1;
      sclk_s3_q  <= 1'b1;
      sdata_s1_q <= 1'b1;
      sdata_s2_q <= 1'b1;
    end else begin
      sclk_s1_q  <= SCLK;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdata_s1_q <= SDATA;
      sdata_s2_q <= sdata_s1_q;
    end
  end

  assign fall = sclk_s3_q & ~sclk_s2_q;

  // Frame FSM, timeout counter and per-frame verdict.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    accept_c  = 1'b0;
    perr_c    = 1'b0;
    ferr_c    = 1'b0;

    // Saturating stall counter, only meaningful inside a frame.
    if (state_q == ST_IDLE || fall)  to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX)     to_cnt_d = to_cnt_q + TW'(1);

    if (state_q != ST_IDLE && !fall && to_cnt_q == TO_MAX) begin
      // Stalled mid-frame: drop the partial frame.
      state_d  = ST_IDLE;
      ferr_c   = 1'b1;
      to_cnt_d = '0;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sdata_s2_q == START_BIT) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d           = shreg_q >> 1;
          shreg_d[DATA_W-1] = sdata_s2_q;
          if (bit_cnt_q == CW'(DATA_W - 1)) state_d = ST_PARITY;
          else                              bit_cnt_d = bit_cnt_q + CW'(1);
        end
        ST_PARITY: begin
          par_d   = sdata_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (sdata_s2_q != STOP_BIT)                       ferr_c   = 1'b1;
          else if ((^{shreg_q, par_q}) != 1'(PARITY_ODD))   perr_c   = 1'b1;
          else                                              accept_c = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, datapath and registered error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      perr_q    <= perr_c;
      ferr_q    <= ferr_c;
    end
  end

  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;

`ifdef PS2_RX_FIFO_EN
  logic fifo_full, fifo_empty;

  // Accepted codes are pushed in the stop-bit cycle so they show at the head
  // with the same latency as the error pulses.
  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (accept_c),
    .push_data (shreg_q),
    .pop       (RD_EN),
    .rd_data   (CODE),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (OVERFLOW)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign NEW_CODE = ~fifo_empty;
`else
  localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;

  logic              new_q, new_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              unused_rd_en;

  // Without a FIFO the last accepted code is held until the next accept.
  always_comb begin
    new_d  = accept_c;
    code_d = accept_c ? shreg_q : code_q;
  end

  // Output register for the pulse and held code.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      new_q  <= 1'b0;
      code_q <= '0;
    end else begin
      new_q  <= new_d;
      code_q <= code_d;
    end
  end

  assign NEW_CODE     = new_q;
  assign CODE         = code_q;
  assign OVERFLOW     = 1'b0;
  assign unused_rd_en = RD_EN;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed table, corner sequences
// (timeout, reset mid-frame, FIFO overflow) and random frames against a
// frame-level reference model.
module tb_ps2_frame_rx;

  localparam int   DW   = 8;
  localparam int   TO   = 300;
  localparam int   HALF = 8;
  localparam logic ODD  = 1'b1;

  logic          CLK = 1'b0;
  logic          RST, SCLK, SDATA, RD_EN;
  logic          NEW_CODE, PARITY_ERR, FRAME_ERR, OVERFLOW;
  logic [DW-1:0] CODE;

  int checks = 0, errors = 0;
  int n_new = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;

  always #5 CLK = ~CLK;

  ps2_frame_rx #(
    .DATA_W(DW), .PARITY_ODD(1), .TIMEOUT_CYC(TO), .FIFO_DEPTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .SDATA(SDATA), .RD_EN(RD_EN),
    .NEW_CODE(NEW_CODE), .CODE(CODE), .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
  );

  // Count high cycles of each output flag, sampled away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (NEW_CODE)   n_new++;
      if (PARITY_ERR) n_perr++;
      if (FRAME_ERR)  n_ferr++;
      if (OVERFLOW)   n_ovf++;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       st;
    logic       en;
    logic       ep;
    logic       ef;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive nb bits of fr (LSB first), one SCLK low pulse per bit.
  task automatic send_bits(input logic [10:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      SDATA = fr[i];
      wait_clk(HALF);
      SCLK = 1'b0;
      wait_clk(HALF);
      SCLK = 1'b1;
    end
    SDATA = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ODD ^ (^d);
  endfunction

  task automatic check_outputs_zero(input string nm);
    chk({nm, " NEW_CODE"},   int'(NEW_CODE),   0);
    chk({nm, " CODE"},       int'(CODE),       0);
    chk({nm, " PARITY_ERR"}, int'(PARITY_ERR), 0);
    chk({nm, " FRAME_ERR"},  int'(FRAME_ERR),  0);
    chk({nm, " OVERFLOW"},   int'(OVERFLOW),   0);
  endtask

  // Send one full frame and compare the outcome with the given expectation.
  task automatic check_frame(input string nm, input logic [7:0] d, input logic p,
                             input logic st, input logic en, input logic ep,
                             input logic ef, input logic [7:0] ec);
    int b_new, b_perr, b_ferr;
    b_new = n_new; b_perr = n_perr; b_ferr = n_ferr;
    send_bits({st, p, d, 1'b0}, 11);
    wait_clk(20);
    chk({nm, " perr"}, n_perr - b_perr, int'(ep));
    chk({nm, " ferr"}, n_ferr - b_ferr, int'(ef));
`ifdef PS2_RX_FIFO_EN
    chk({nm, " new"}, int'(NEW_CODE), int'(en));
    if (en) begin
      chk({nm, " code"}, int'(CODE), int'(ec));
      RD_EN = 1'b1;
      wait_clk(1);
      RD_EN = 1'b0;
      wait_clk(1);
      chk({nm, " drained"}, int'(NEW_CODE), 0);
    end
`else
    chk({nm, " new"}, n_new - b_new, int'(en));
    chk({nm, " code"}, int'(CODE), int'(ec));
`endif
  endtask

  initial begin
    logic [7:0] d, last_code;
    logic       p, st, en, ep, ef;
    int         b_new, b_perr, b_ferr, b_ovf;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C};
    tbl[1] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1C};
    tbl[2] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    tbl[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12};
    tbl[4] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

    RST = 1'b1; SCLK = 1'b1; SDATA = 1'b1; RD_EN = 1'b0;
    wait_clk(3);
    check_outputs_zero("reset");
    RST = 1'b0;
    wait_clk(5);
    check_outputs_zero("post_reset");

    for (int i = 0; i < 8; i++)
      check_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].p, tbl[i].st,
                  tbl[i].en, tbl[i].ep, tbl[i].ef, tbl[i].ec);

    // Stall after start + 4 data bits until the frame times out.
    b_new = n_new; b_perr = n_perr; b_ferr = n_ferr;
    send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 5);
    wait_clk(TO + 30);
    chk("timeout ferr", n_ferr - b_ferr, 1);
    chk("timeout perr", n_perr - b_perr, 0);
`ifdef PS2_RX_FIFO_EN
    chk("timeout new", int'(NEW_CODE), 0);
`else
    chk("timeout new", n_new - b_new, 0);
`endif
    check_frame("after_timeout", 8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h29);

    // Reset in the middle of a frame, then a clean frame.
    send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 4);
    RST = 1'b1;
    wait_clk(2);
    check_outputs_zero("mid_reset");
    wait_clk(3);
    RST = 1'b0;
    wait_clk(5);
    check_frame("after_reset", 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33);

    // Random frames against the frame-level model.
    last_code = 8'h33;
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      p  = ($urandom_range(0, 4) == 0) ? ~good_par(d) : good_par(d);
      st = ($urandom_range(0, 9) != 0);
      ef = ~st;
      ep = st & ((^{d, p}) != ODD);
      en = st & ~ep;
      if (en) last_code = d;
      check_frame($sformatf("rnd%0d", i), d, p, st, en, ep, ef, last_code);
    end

`ifdef PS2_RX_FIFO_EN
    // Fill beyond capacity, then drain in order.
    for (int k = 1; k <= 9; k++) begin
      b_ovf = n_ovf;
      send_bits({1'b1, good_par(8'(k)), 8'(k), 1'b0}, 11);
      wait_clk(20);
      chk($sformatf("fill%0d ovf", k), n_ovf - b_ovf, (k == 9) ? 1 : 0);
    end
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("pop%0d new", k), int'(NEW_CODE), 1);
      chk($sformatf("pop%0d code", k), int'(CODE), k);
      RD_EN = 1'b1;
      wait_clk(1);
      RD_EN = 1'b0;
    end
    chk("drained new", int'(NEW_CODE), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
